wash_countdown_timer: RTL
=========================

# wash_countdown_timer

Wash-cycle countdown timer that holds the remaining time of the current wash phase as minutes and seconds. It counts down once per second under start/pause/stop control and drives the 14-bit decimal display value (MM*100+SS, 0..9959) into the 4-digit FND display stage. It sits directly upstream of the FND display block. It is controlled by the wash-sequence controller, which loads phase durations and consumes the done pulse.

## Interface
- TICK_DIV, default 100_000_000 — sysclk cycles per 1 s tick; simulation uses small values; legal range ≥2.
- sysclk  in  1  system clock; all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_load  in  1  single-cycle pulse: capture i_min/i_sec as phase duration.
- i_min  in  7  minutes, 0..99; values >99 clamp to 99.
- i_sec  in  6  seconds, 0..59; values >59 clamp to 59.
- i_start  in  1  pulse: begin or resume countdown.
- i_pause  in  1  pulse: freeze countdown.
- i_stop  in  1  pulse: abort, restore loaded duration.
- o_fndData  out  14  remaining time as MM*100+SS, registered.
- o_state  out  2  0=IDLE, 1=RUN, 2=PAUSE, 3=DONE.
- o_done  out  1  one-cycle pulse when countdown reaches 00:00.

## Operation
- Internal registers:
  - shadow duration: sh_min[6:0], sh_sec[5:0];
  - remaining time: rem_min[6:0], rem_sec[5:0];
  - tick prescaler count [$clog2(TICK_DIV)-1:0].
- Priority when several pulses coincide: i_stop > i_pause > i_start > i_load. Only the highest applicable pulse acts; the others are dropped.
- IDLE:
  - i_load → shadow and remaining both take the clamped inputs.
  - i_start with remaining ≠ 0 → RUN, prescaler cleared to 0.
  - i_start with remaining = 0 → ignored.
  - i_pause and i_stop → ignored.
- RUN:
  - Prescaler increments each cycle; tick when count = TICK_DIV-1, then count wraps to 0.
  - On tick: if rem_sec > 0, rem_sec decrements. Otherwise rem_min decrements and rem_sec becomes 59.
  - If a tick's result is 00:00 → DONE and o_done asserted, both in the same cycle the result is registered.
  - i_pause → PAUSE, prescaler frozen (fractional second retained).
  - i_stop → IDLE, remaining ← shadow.
  - i_load → ignored.
- PAUSE:
  - i_start → RUN, prescaler resumes from its frozen value.
  - i_stop → IDLE, remaining ← shadow.
  - i_load → ignored.
- DONE:
  - Remaining holds 00:00.
  - i_load → IDLE with new values.
  - i_start → RUN with remaining ← shadow and prescaler cleared, provided shadow ≠ 0.
  - i_stop → IDLE, remaining ← shadow.
- A tick coinciding with i_pause or i_stop: the pulse wins and no decrement occurs.
- Arithmetic: o_fndData = rem_min*100 + rem_sec, 14 bits. Maximum 9959, so no overflow.

## Timing
- Reset values:
  - o_state = IDLE, o_fndData = 0, o_done = 0;
  - shadow, remaining and prescaler all 0.
- Reset has priority over every input.
- Reset mid-RUN returns to IDLE with 00:00 and discards the shadow.
- Latency:
  - Control pulse at edge n → o_state and remaining registers update at edge n.
  - o_fndData reflects remaining from edge n+1 (one register stage).
- First tick after start lands TICK_DIV cycles after the start edge.
- o_done is exactly one cycle high per completion and is never asserted in any other state transition.
- Inputs are synchronous single-cycle pulses. A level held high is re-evaluated each cycle under the same priority rules.

## Structure
- Package wash_timer_pkg:
  - state enum {IDLE, RUN, PAUSE, DONE} (2 bits);
  - constants MAX_MIN=99, MAX_SEC=59.
- Sub-module wash_tick_gen:
  - enable-gated, clearable prescaler with parameter TICK_DIV;
  - inputs sysclk, i_rst, i_en, i_clr;
  - output o_tick.
- Top module holds the FSM, clamp logic, mm:ss counters and the binary-to-decimal output register.

## Test plan
TICK_DIV=4 for all scenarios.
- **Load and countdown:** load i_min=1, i_sec=2, then start → o_fndData steps 102, 101, 100, 59, …, 1, 0 every 4 cycles. o_done pulses once at 0 and o_state=3.
- **Clamping:** load i_min=120, i_sec=63 → o_fndData=9959 two cycles after the load pulse.
- **Pause/resume:** pause 2 cycles into a second, hold 20 cycles, then resume → no decrement while paused. Next decrement arrives 2 cycles after resume.
- **Stop:** load 0:05, start, stop at 0:03 → o_state=0 and o_fndData returns to 5. A subsequent start counts from 5.
- **Zero start and simultaneous pulses:** start with 00:00 loaded → o_state stays 0. i_start and i_stop together in PAUSE → IDLE (stop wins).
- **Reset mid-RUN:** assert i_rst during RUN at 0:40 → next cycle o_state=0, o_done=0, o_fndData=0 one cycle later. A following start is ignored.

Source files
------------

// File: rtl/wash_timer_pkg.sv
// Shared types and limits for the wash-cycle countdown timer.
package wash_timer_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StPause = 2'd2,
      StDone  = 2'd3
   } wash_state_e;

   localparam logic [6:0] MaxMin = 7'd99;
   localparam logic [5:0] MaxSec = 6'd59;

   function automatic logic [13:0] to_fnd(input logic [6:0] mm, input logic [5:0] ss);
      return 14'(mm) * 14'd100 + 14'(ss);
   endfunction

endpackage

// File: rtl/wash_tick_gen.sv
// One-second tick prescaler: counts while enabled, holds when disabled, clear wins.
module wash_tick_gen #(
   parameter int unsigned TICK_DIV = 100_000_000
) (
   input  logic sysclk,
   input  logic i_rst,
   input  logic i_en,
   input  logic i_clr,
   output logic o_tick
);

   localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   assign o_tick = i_en && (cnt_q == CntMax);

   always_comb begin
      cnt_d = cnt_q;
      if (i_clr) begin
         cnt_d = '0;
      end else if (i_en) begin
         cnt_d = o_tick ? '0 : cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge sysclk) begin
      if (i_rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/wash_countdown_timer.sv
// Wash-phase mm:ss countdown with start/pause/stop control and decimal display output.
module wash_countdown_timer
   import wash_timer_pkg::*;
#(
   parameter int unsigned TICK_DIV = 100_000_000
) (
   input  logic        sysclk,
   input  logic        i_rst,
   input  logic        i_load,
   input  logic [6:0]  i_min,
   input  logic [5:0]  i_sec,
   input  logic        i_start,
   input  logic        i_pause,
   input  logic        i_stop,
   output logic [13:0] o_fndData,
   output logic [1:0]  o_state,
   output logic        o_done
);

   wash_state_e state_q, state_d;
   logic [6:0]  sh_min_q, sh_min_d, rem_min_q, rem_min_d, min_clamp;
   logic [5:0]  sh_sec_q, sh_sec_d, rem_sec_q, rem_sec_d, sec_clamp;
   logic        done_q, done_d;
   logic [13:0] fnd_q;
   logic        tick, tick_en, tick_clr, rem_zero, sh_zero;

   assign min_clamp = (i_min > MaxMin) ? MaxMin : i_min;
   assign sec_clamp = (i_sec > MaxSec) ? MaxSec : i_sec;
   assign rem_zero  = (rem_min_q == '0) && (rem_sec_q == '0);
   assign sh_zero   = (sh_min_q == '0) && (sh_sec_q == '0);

   // A coinciding pause/stop must also freeze the prescaler, not just block the decrement.
   assign tick_en = (state_q == StRun) && !i_stop && !i_pause;

   wash_tick_gen #(
      .TICK_DIV(TICK_DIV)
   ) u_tick_gen (
      .sysclk(sysclk),
      .i_rst (i_rst),
      .i_en  (tick_en),
      .i_clr (tick_clr),
      .o_tick(tick)
   );

   always_comb begin
      state_d   = state_q;
      sh_min_d  = sh_min_q;
      sh_sec_d  = sh_sec_q;
      rem_min_d = rem_min_q;
      rem_sec_d = rem_sec_q;
      done_d    = 1'b0;
      tick_clr  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (i_start && !rem_zero) begin
               state_d  = StRun;
               tick_clr = 1'b1;
            end else if (i_load) begin
               sh_min_d  = min_clamp;
               sh_sec_d  = sec_clamp;
               rem_min_d = min_clamp;
               rem_sec_d = sec_clamp;
            end
         end
         StRun: begin
            if (i_stop) begin
               state_d   = StIdle;
               rem_min_d = sh_min_q;
               rem_sec_d = sh_sec_q;
            end else if (i_pause) begin
               state_d = StPause;
            end else if (tick) begin
               if (rem_sec_q != '0) begin
                  rem_sec_d = rem_sec_q - 6'd1;
               end else begin
                  rem_min_d = rem_min_q - 7'd1;
                  rem_sec_d = MaxSec;
               end
               if ((rem_min_q == '0) && (rem_sec_q == 6'd1)) begin
                  state_d = StDone;
                  done_d  = 1'b1;
               end
            end
         end
         StPause: begin
            if (i_stop) begin
               state_d   = StIdle;
               rem_min_d = sh_min_q;
               rem_sec_d = sh_sec_q;
            end else if (i_start) begin
               state_d = StRun;
            end
         end
         StDone: begin
            if (i_stop) begin
               state_d   = StIdle;
               rem_min_d = sh_min_q;
               rem_sec_d = sh_sec_q;
            end else if (i_start && !sh_zero) begin
               state_d   = StRun;
               tick_clr  = 1'b1;
               rem_min_d = sh_min_q;
               rem_sec_d = sh_sec_q;
            end else if (i_load) begin
               state_d   = StIdle;
               sh_min_d  = min_clamp;
               sh_sec_d  = sec_clamp;
               rem_min_d = min_clamp;
               rem_sec_d = sec_clamp;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge sysclk) begin
      if (i_rst) begin
         state_q   <= StIdle;
         sh_min_q  <= '0;
         sh_sec_q  <= '0;
         rem_min_q <= '0;
         rem_sec_q <= '0;
         done_q    <= 1'b0;
         fnd_q     <= '0;
      end else begin
         state_q   <= state_d;
         sh_min_q  <= sh_min_d;
         sh_sec_q  <= sh_sec_d;
         rem_min_q <= rem_min_d;
         rem_sec_q <= rem_sec_d;
         done_q    <= done_d;
         fnd_q     <= to_fnd(rem_min_q, rem_sec_q);
      end
   end

   assign o_fndData = fnd_q;
   assign o_state   = state_q;
   assign o_done    = done_q;

endmodule
